// File: rtl/icache_line_refill.sv
// Instruction-cache miss refill engine: bursts one line from memory into the data RAM,
// commits the tag when the burst ends, and sweeps all tags invalid after reset or on flush.
module icache_line_refill #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_BYTES = 32,
   parameter int SET_BITS   = 7,
   localparam int WORDS     = LINE_BYTES / (DATA_WIDTH / 8),
   localparam int OFF_BITS  = $clog2(LINE_BYTES),
   localparam int WORD_BITS = $clog2(WORDS),
   localparam int TAG_BITS  = ADDR_WIDTH - SET_BITS - OFF_BITS
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          flush_req,
   input  logic                          miss_valid,
   output logic                          miss_ready,
   input  logic [ADDR_WIDTH-1:0]         miss_address,
   output logic                          busy,
   output logic                          mem_cmd_valid,
   input  logic                          mem_cmd_ready,
   output logic [ADDR_WIDTH-1:0]         mem_cmd_address,
   input  logic                          mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
   input  logic                          mem_rsp_error,
   output logic                          data_wr_en,
   output logic [SET_BITS+WORD_BITS-1:0] data_wr_addr,
   output logic [DATA_WIDTH-1:0]         data_wr_data,
   output logic                          tag_wr_en,
   output logic [SET_BITS-1:0]           tag_wr_addr,
   output logic [TAG_BITS+1:0]           tag_wr_data,
   output logic                          refill_done,
   output logic                          refill_error
);

   typedef enum logic [2:0] {FLUSH, IDLE, CMD, FILL, COMMIT} state_t;

   state_t                  state_q, state_d;
   logic [SET_BITS-1:0]     flush_cnt_q, flush_cnt_d;
   logic [WORD_BITS-1:0]    word_cnt_q, word_cnt_d;
   logic                    err_q, err_d;
   logic                    pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;

   logic [SET_BITS-1:0]     line_set;
   logic [TAG_BITS-1:0]     line_tag;

   assign line_set = line_addr_q[OFF_BITS +: SET_BITS];
   assign line_tag = line_addr_q[ADDR_WIDTH-1 -: TAG_BITS];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= FLUSH;
         flush_cnt_q <= '0;
         word_cnt_q  <= '0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         line_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         word_cnt_q  <= word_cnt_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         line_addr_q <= line_addr_d;
      end
   end

   // Outputs are decoded from state, but gated by resetn so every output reads 0 while reset is held.
   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      word_cnt_d      = word_cnt_q;
      err_d           = err_q;
      pend_d          = pend_q;
      line_addr_d     = line_addr_q;
      miss_ready      = 1'b0;
      busy            = 1'b0;
      mem_cmd_valid   = 1'b0;
      mem_cmd_address = '0;
      data_wr_en      = 1'b0;
      data_wr_addr    = '0;
      data_wr_data    = '0;
      tag_wr_en       = 1'b0;
      tag_wr_addr     = '0;
      tag_wr_data     = '0;
      refill_done     = 1'b0;
      refill_error    = 1'b0;

      if (resetn) begin
         busy = (state_q != IDLE);
         if (flush_req && (state_q == CMD || state_q == FILL || state_q == COMMIT))
            pend_d = 1'b1;

         case (state_q)
            FLUSH: begin
               tag_wr_en   = 1'b1;
               tag_wr_addr = flush_cnt_q;
               flush_cnt_d = flush_cnt_q + 1'b1;
               if (&flush_cnt_q)
                  state_d = IDLE;
            end
            IDLE: begin
               if (flush_req || pend_q) begin
                  state_d     = FLUSH;
                  pend_d      = 1'b0;
                  flush_cnt_d = '0;
               end else begin
                  miss_ready = 1'b1;
                  if (miss_valid) begin
                     line_addr_d = miss_address & ~ADDR_WIDTH'(LINE_BYTES - 1);
                     err_d       = 1'b0;
                     state_d     = CMD;
                  end
               end
            end
            CMD: begin
               mem_cmd_valid   = 1'b1;
               mem_cmd_address = line_addr_q;
               if (mem_cmd_ready) begin
                  word_cnt_d = '0;
                  state_d    = FILL;
               end
            end
            FILL: begin
               if (mem_rsp_valid) begin
                  data_wr_en   = 1'b1;
                  data_wr_addr = {line_set, word_cnt_q};
                  data_wr_data = mem_rsp_data;
                  err_d        = err_q | mem_rsp_error;
                  word_cnt_d   = word_cnt_q + 1'b1;
                  if (word_cnt_q == WORD_BITS'(WORDS - 1))
                     state_d = COMMIT;
               end
            end
            COMMIT: begin
               tag_wr_en    = 1'b1;
               tag_wr_addr  = line_set;
               tag_wr_data  = {line_tag, err_q, 1'b1};
               refill_done  = 1'b1;
               refill_error = err_q;
               state_d      = IDLE;
            end
            default: state_d = FLUSH;
         endcase
      end
   end

endmodule
